reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits, minimum 1.
REQ-002 Parameter DEPTH, default 8: number of registers, minimum 2, need not be a power of 2.
REQ-003 Parameter BYPASS, default 1: 1 forwards write data to same-cycle reads; 0 means reads show pre-edge contents only.
REQ-004 Derived AW = clog2(DEPTH): address width.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in  in  WIDTH  write data.
REQ-008 load  in  1  write request for the current cycle.
REQ-009 waddr  in  AW  write address.
REQ-010 raddr_a  in  AW  read port A address.
REQ-011 raddr_b  in  AW  read port B address.
REQ-012 clear  in  1  request to start a clear sweep.
REQ-013 out_a  out  WIDTH  read port A data, combinational.
REQ-014 out_b  out  WIDTH  read port B data, combinational.
REQ-015 busy  out  1  registered; high while a clear sweep runs.
REQ-016 wr_ack  out  1  registered; one-cycle pulse the cycle after a write commits.
REQ-017 wr_drop  out  1  registered; one-cycle pulse the cycle after a load is rejected.

Function
REQ-018 A write is accepted when load=1, busy=0, clear=0 and waddr<DEPTH; reg[waddr] takes in at the edge.
REQ-019 Out-of-range accesses (address>=DEPTH):
- A write is ignored and produces neither wr_ack nor wr_drop.
- A read returns 0.
REQ-020 Reads are combinational: out_a=reg[raddr_a] and out_b=reg[raddr_b]; both ports may use the same address.
REQ-021 With BYPASS=1, an accepted write whose waddr equals a read address drives in on that port in the same cycle; with BYPASS=0 no forwarding occurs.
REQ-022 FSM states are IDLE and SWEEP.
REQ-023 IDLE to SWEEP: clear=1 in IDLE; at that edge the pointer loads 0 and busy goes to 1.
REQ-024 In SWEEP, each edge zeroes reg[ptr] and increments ptr.
REQ-025 The edge that zeroes reg[DEPTH-1] returns the FSM to IDLE with busy=0, so busy stays high for exactly DEPTH cycles.
REQ-026 clear while in SWEEP is ignored; the sweep does not restart.
REQ-027 load=1 while busy=1, or together with clear=1 in IDLE, is rejected (clear has priority): no write, wr_drop=1 next cycle.
REQ-028 Reads during SWEEP return current contents: entries already swept read 0, the rest read their old values.
REQ-029 Registers not addressed by an accepted write or by the sweep hold their value.
REQ-030 wr_ack and wr_drop are never high in the same cycle.

Reset
REQ-031 rst_n=0 immediately sets all registers to 0, FSM to IDLE, ptr to 0, and busy, wr_ack, wr_drop to 0.
REQ-032 Reset asserted mid-sweep abandons the sweep; after release the block is IDLE and accepts writes on the first edge.
REQ-033 Reset overrides load and clear in every cycle it is asserted.

Structure
REQ-034 Shared package hack_pkg holds WORD_W=16, the sweep state enum (IDLE, SWEEP) and the clog2 helper function.
REQ-035 One sub-module, reg_cell: a WIDTH-bit register with load, synchronous clear and async active-low reset, instantiated DEPTH times.
REQ-036 Address decode, read muxes, bypass logic and the FSM live in reg_file.

Verification
REQ-037 Write and read, default params:
- Stimulus: write 16'h0912 to addr 3, then write 16'hFFFF to addr 5.
- Response: raddr_a=3 gives 0912, raddr_b=5 gives FFFF, wr_ack pulses once per write.
REQ-038 Bypass:
- Stimulus: load=1, waddr=2, in=16'hABCD, raddr_a=2, all in the same cycle.
- Response: BYPASS=1 shows ABCD that cycle; BYPASS=0 shows the old value, then ABCD after the edge.
REQ-039 Sweep:
- Stimulus: fill addrs 0-7 with nonzero data, pulse clear.
- Response: busy high exactly 8 cycles; all reads 0 afterwards; after 3 sweep edges addr 2 reads 0 and addr 3 keeps its data.
REQ-040 Rejection:
- Stimulus: load during busy; then load and clear together in IDLE.
- Response: wr_drop pulses each time, target register is not written, wr_ack stays 0.
REQ-041 Reset mid-sweep:
- Stimulus: assert rst_n=0 at sweep cycle 4, then release.
- Response: busy=0 immediately and all registers 0; a write of 16'h1234 to addr 6 on the next edge reads back 1234.
REQ-042 Odd depth:
- Stimulus: DEPTH=5, write to addr 6.
- Response: write ignored with no wr_ack and no wr_drop, reads of addr 6 return 0, sweep lasts exactly 5 cycles.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the register file: default word width, sweep FSM states
// and an elaboration-time ceil(log2) helper.
package hack_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic {
    IDLE,
    SWEEP
  } sweep_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_cell.sv
// One storage word with async reset, synchronous clear and load enable.
module reg_cell #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with optional write-to-read forwarding and a
// one-entry-per-cycle clear sweep that blocks writes while it runs.
module reg_file
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH  = WORD_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [AW-1:0]    waddr,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  input  logic             clear,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             busy,
  output logic             wr_ack,
  output logic             wr_drop
);

  localparam logic [AW:0]   Limit = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] Last  = AW'(DEPTH - 1);

  sweep_state_e   state;
  logic [AW-1:0]  ptr;
  logic [WIDTH-1:0] regs [DEPTH];

  logic waddr_ok, ra_ok, rb_ok;
  logic wr_ok, wr_rej;

  assign waddr_ok = {1'b0, waddr} < Limit;
  assign ra_ok    = {1'b0, raddr_a} < Limit;
  assign rb_ok    = {1'b0, raddr_b} < Limit;

  // Clear has priority over load; out-of-range loads are silently ignored.
  assign wr_ok  = load & ~busy & ~clear & waddr_ok;
  assign wr_rej = load & waddr_ok & (busy | clear);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic cell_load, cell_clr;
    assign cell_load = wr_ok && (waddr == AW'(i));
    assign cell_clr  = (state == SWEEP) && (ptr == AW'(i));

    reg_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cell_load),
      .clear (cell_clr),
      .d     (in),
      .q     (regs[i])
    );
  end

  always_comb begin
    out_a = '0;
    if (ra_ok) begin
      out_a = regs[raddr_a];
      if ((BYPASS != 0) && wr_ok && (waddr == raddr_a)) begin
        out_a = in;
      end
    end
  end

  always_comb begin
    out_b = '0;
    if (rb_ok) begin
      out_b = regs[raddr_b];
      if ((BYPASS != 0) && wr_ok && (waddr == raddr_b)) begin
        out_b = in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      busy    <= 1'b0;
      wr_ack  <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_ack  <= wr_ok;
      wr_drop <= wr_rej;
      case (state)
        IDLE: begin
          if (clear) begin
            state <= SWEEP;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (ptr == Last) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Drives three register-file variants (default, no bypass, depth 5) with shared stimulus
// and checks every cycle against an array-based model through a scoreboard queue.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n, load, clear;
  logic [15:0] din;
  logic [2:0]  waddr, raddr_a, raddr_b;

  logic [15:0] oa [3];
  logic [15:0] ob [3];
  logic        bsy [3];
  logic        ack [3];
  logic        drp [3];

  typedef struct packed {
    logic [2:0][15:0] a;
    logic [2:0][15:0] b;
    logic [2:0]       busy;
    logic [2:0]       ack;
    logic [2:0]       drop;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   stim_done = 1'b0;

  // Reference model state, one slot per DUT variant.
  logic [15:0] mem [3][8];
  bit          sweeping [3];
  int          sidx [3];
  bit          m_ack [3];
  bit          m_drop [3];

  always #5 clk = ~clk;

  reg_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(din), .load(load), .waddr(waddr), .raddr_a(raddr_a),
    .raddr_b(raddr_b), .clear(clear), .out_a(oa[0]), .out_b(ob[0]), .busy(bsy[0]),
    .wr_ack(ack[0]), .wr_drop(drp[0]));

  reg_file #(.WIDTH(16), .DEPTH(8), .BYPASS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(din), .load(load), .waddr(waddr), .raddr_a(raddr_a),
    .raddr_b(raddr_b), .clear(clear), .out_a(oa[1]), .out_b(ob[1]), .busy(bsy[1]),
    .wr_ack(ack[1]), .wr_drop(drp[1]));

  reg_file #(.WIDTH(16), .DEPTH(5), .BYPASS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in(din), .load(load), .waddr(waddr), .raddr_a(raddr_a),
    .raddr_b(raddr_b), .clear(clear), .out_a(oa[2]), .out_b(ob[2]), .busy(bsy[2]),
    .wr_ack(ack[2]), .wr_drop(drp[2]));

  function automatic int dep(input int k);
    return (k == 2) ? 5 : 8;
  endfunction

  function automatic bit byp(input int k);
    return (k == 1) ? 1'b0 : 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) mem[k][i] = '0;
      sweeping[k] = 1'b0;
      sidx[k]     = 0;
      m_ack[k]    = 1'b0;
      m_drop[k]   = 1'b0;
    end
  endtask

  function automatic logic [15:0] model_read(input int k, input int a, input bit acc);
    if (a >= dep(k)) return '0;
    if (byp(k) && acc && (int'(waddr) == a)) return din;
    return mem[k][a];
  endfunction

  // Apply one cycle of inputs, queue the expected pre-edge outputs, then advance the model.
  task automatic cycle(input logic r, input logic l, input logic c, input logic [15:0] d,
                       input logic [2:0] wa, input logic [2:0] ra, input logic [2:0] rb);
    exp_t e;
    bit   acc, inr;
    rst_n = r; load = l; clear = c; din = d; waddr = wa; raddr_a = ra; raddr_b = rb;
    if (!r) model_reset();
    for (int k = 0; k < 3; k++) begin
      inr = int'(wa) < dep(k);
      acc = r && l && inr && !sweeping[k] && !c;
      e.a[k]    = model_read(k, int'(ra), acc);
      e.b[k]    = model_read(k, int'(rb), acc);
      e.busy[k] = sweeping[k];
      e.ack[k]  = m_ack[k];
      e.drop[k] = m_drop[k];
      if (r) begin
        m_ack[k]  = acc;
        m_drop[k] = l && inr && (sweeping[k] || c);
        if (acc) mem[k][wa] = d;
        if (sweeping[k]) begin
          mem[k][sidx[k]] = '0;
          sidx[k] = sidx[k] + 1;
          if (sidx[k] == dep(k)) sweeping[k] = 1'b0;
        end else if (c) begin
          sweeping[k] = 1'b1;
          sidx[k]     = 0;
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int k, input logic [15:0] got,
                     input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%h want=%h", name, k, $time, got, want);
    end
  endtask

  // Monitor: outputs are valid every cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
          chk("out_a", k, oa[k], e.a[k]);
          chk("out_b", k, ob[k], e.b[k]);
          chk("busy", k, 16'(bsy[k]), 16'(e.busy[k]));
          chk("wr_ack", k, 16'(ack[k]), 16'(e.ack[k]));
          chk("wr_drop", k, 16'(drp[k]), 16'(e.drop[k]));
          total++;
          if (ack[k] && drp[k]) begin
            bad++;
            $display("FAIL ack_drop_excl dut%0d t=%0t got=both want=at_most_one", k, $time);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; clear = 1'b0; din = '0;
    waddr = '0; raddr_a = '0; raddr_b = '0;
    model_reset();
    @(posedge clk);
    #1;
    cycle(0, 0, 0, 16'h0, 0, 0, 0);
    cycle(0, 1, 1, 16'hDEAD, 1, 1, 2);
    // Basic writes and readback.
    cycle(1, 1, 0, 16'h0912, 3, 3, 5);
    cycle(1, 1, 0, 16'hFFFF, 5, 3, 5);
    cycle(1, 0, 0, 16'h0, 0, 3, 5);
    // Same-cycle forwarding.
    cycle(1, 1, 0, 16'hABCD, 2, 2, 3);
    cycle(1, 0, 0, 16'h0, 0, 2, 2);
    // Out-of-range for the depth-5 variant.
    cycle(1, 1, 0, 16'h6666, 6, 6, 5);
    cycle(1, 0, 0, 16'h0, 0, 6, 6);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 16'h1100 + 16'(i) + 16'h1, 3'(i), 3'(i), 3);
    cycle(1, 0, 1, 16'h0, 0, 2, 3);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 16'h0, 0, 2, 3);
    cycle(1, 1, 1, 16'h5555, 7, 7, 3);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 16'h0, 0, 3'(i), 7);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 16'h0, 0, 3'(i), 3'(7 - i));
    // Load together with clear in IDLE: rejected, sweep starts.
    cycle(1, 1, 1, 16'h7777, 4, 4, 4);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 16'h0, 0, 4, 0);
    // Reset at sweep cycle 4, then write on the first edge after release.
    cycle(0, 1, 0, 16'h9999, 1, 4, 6);
    cycle(1, 1, 0, 16'h1234, 6, 6, 1);
    cycle(1, 0, 0, 16'h0, 0, 6, 6);
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 149) != 0), $urandom_range(0, 1), ($urandom_range(0, 24) == 0),
            16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)));
    end
    cycle(1, 0, 0, 16'h0, 0, 0, 0);
    stim_done = 1'b1;
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
